// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encoding and
// timeout counter width.
package wb_arb_pkg;

    localparam int STATE_W = 2;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_ABORT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin pick: first requester strictly after 'last',
// wrapping, returned as one-hot grant plus index.
module wb_rr_pick #(
    parameter int NumReq = 4,
    parameter int IdxW   = 2
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   last,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx,
    output logic              valid
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        // i runs 1..NumReq so 'last' itself is considered only after everyone else
        for (int i = 1; i <= NumReq; i++) begin
            cand = IdxW'((int'(last) + i) % NumReq);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NumMasters masters,
// with a stalled-strobe timeout that aborts the owner's cycle.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NumMasters    = 4,
    parameter int AddrWidth     = 16,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumMasters-1:0]           m_cyc_i,
    input  logic [NumMasters-1:0]           m_stb_i,
    input  logic [NumMasters-1:0]           m_we_i,
    input  logic [NumMasters*AddrWidth-1:0] m_adr_i,
    input  logic [NumMasters*DataWidth-1:0] m_dat_i,
    output logic [NumMasters-1:0]           m_ack_o,
    output logic [NumMasters-1:0]           m_err_o,
    output logic [DataWidth-1:0]            m_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [AddrWidth-1:0]            s_adr_o,
    output logic [DataWidth-1:0]            s_dat_o,
    input  logic [DataWidth-1:0]            s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [NumMasters-1:0]           gnt_o,
    output logic                            timeout_o,
    output logic [STATE_W-1:0]              actual_state_o
);

    localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;

    arb_state_e            state;
    logic [IdxW-1:0]       owner;
    logic [IdxW-1:0]       last_owner;
    logic [CNT_W-1:0]      cnt;
    logic [NumMasters-1:0] pick_gnt;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_valid;
    logic                  busy;
    logic                  own_cyc;
    logic                  own_stb;
    logic                  expire;

    wb_rr_pick #(
        .NumReq(NumMasters),
        .IdxW  (IdxW)
    ) u_pick (
        .req  (m_cyc_i),
        .last (last_owner),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    assign busy    = (state == ST_BUSY);
    assign own_cyc = m_cyc_i[owner];
    assign own_stb = m_stb_i[owner];
    // A slave response in the limit cycle wins over the abort.
    assign expire  = own_stb && !s_ack_i && !s_err_i && (cnt == CNT_W'(TimeoutCycles));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            gnt_o      <= '0;
            owner      <= '0;
            last_owner <= IdxW'(NumMasters - 1);
            cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (pick_valid) begin
                        owner <= pick_idx;
                        gnt_o <= pick_gnt;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!own_cyc) begin
                        state <= ST_RELEASE;
                        gnt_o <= '0;
                        cnt   <= '0;
                    end else if (expire) begin
                        state <= ST_ABORT;
                        cnt   <= '0;
                    end else if (s_ack_i || s_err_i || !own_stb) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    state <= ST_RELEASE;
                    gnt_o <= '0;
                end
                ST_RELEASE: begin
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    gnt_o <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o = busy & own_cyc;
        s_stb_o = busy & own_stb;
        s_we_o  = busy & m_we_i[owner];
        s_adr_o = busy ? m_adr_i[int'(owner)*AddrWidth +: AddrWidth] : '0;
        s_dat_o = busy ? m_dat_i[int'(owner)*DataWidth +: DataWidth] : '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy) begin
            m_ack_o[owner] = s_ack_i;
            m_err_o[owner] = s_err_i;
        end else if (state == ST_ABORT) begin
            m_err_o[owner] = 1'b1;
        end
    end

    assign timeout_o      = (state == ST_ABORT);
    assign m_dat_o        = s_dat_i;
    assign actual_state_o = state;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: grant order, data routing, timeout abort,
// ack/timeout race and asynchronous reset.
module tb_wb_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  m_cyc;
    logic [3:0]  m_stb;
    logic [3:0]  m_we;
    logic [63:0] m_adr;
    logic [63:0] m_dat;
    logic [3:0]  m_ack_o;
    logic [3:0]  m_err_o;
    logic [15:0] m_dat_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_we_o;
    logic [15:0] s_adr_o;
    logic [15:0] s_dat_o;
    logic [15:0] s_dat;
    logic        s_ack;
    logic        s_err;
    logic [3:0]  gnt_o;
    logic        timeout_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    wb_rr_arbiter #(
        .NumMasters   (4),
        .AddrWidth    (16),
        .DataWidth    (16),
        .TimeoutCycles(4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .m_cyc_i       (m_cyc),
        .m_stb_i       (m_stb),
        .m_we_i        (m_we),
        .m_adr_i       (m_adr),
        .m_dat_i       (m_dat),
        .m_ack_o       (m_ack_o),
        .m_err_o       (m_err_o),
        .m_dat_o       (m_dat_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_we_o        (s_we_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_dat_i       (s_dat),
        .s_ack_i       (s_ack),
        .s_err_i       (s_err),
        .gnt_o         (gnt_o),
        .timeout_o     (timeout_o),
        .actual_state_o(state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc = '0;
        m_stb = '0;
        m_we  = '0;
        s_ack = 1'b0;
        s_err = 1'b0;
    endtask

    task automatic reset_pulse();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic request(input int m);
        m_cyc[m] = 1'b1;
        m_stb[m] = 1'b1;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    initial begin
        int zeros;
        int stalled;
        int own;
        logic [31:0] exp;

        rst   = 1'b1;
        clear_inputs();
        m_adr = '0;
        m_dat = '0;
        s_dat = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            m_adr[k*16 +: 16] = 16'hA000 + 16'(k);
            m_dat[k*16 +: 16] = 16'hD000 + 16'(k);
        end
        step();
        step();

        // reset state
        check_eq("rst_gnt", 32'(gnt_o), 32'h0);
        check_eq("rst_state", 32'(state_o), 32'h0);
        check_eq("rst_scyc", 32'(s_cyc_o), 32'h0);
        check_eq("rst_timeout", 32'(timeout_o), 32'h0);
        check_eq("rst_mdat_follow", 32'(m_dat_o), 32'h1234);
        rst = 1'b0;

        // scenario: 0101 request right after reset
        m_cyc = 4'b0101;
        m_stb = 4'b0101;
        settle();
        check_eq("s1_idle_gnt", 32'(gnt_o), 32'h0);
        step();
        check_eq("s1_gnt0", 32'(gnt_o), 32'b0001);
        check_eq("s1_busy", 32'(state_o), 32'd1);
        check_eq("s1_sadr", 32'(s_adr_o), 32'hA000);
        s_ack = 1'b1;
        settle();
        check_eq("s1_ack0", 32'(m_ack_o), 32'b0001);
        s_ack = 1'b0;
        drop(0);
        step();
        check_eq("s1_release", 32'(state_o), 32'd3);
        check_eq("s1_rel_gnt", 32'(gnt_o), 32'h0);
        step();
        check_eq("s1_idle", 32'(state_o), 32'd0);
        step();
        check_eq("s1_gnt2", 32'(gnt_o), 32'b0100);
        drop(2);
        step();
        step();

        // scenario: all four requesting, single transfers
        reset_pulse();
        m_cyc = 4'b1111;
        m_stb = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int g = 0; g < 5; g++) begin
            zeros = 0;
            while (gnt_o == 4'b0 && zeros < 10) begin
                zeros++;
                step();
            end
            if (gnt_o == 4'b0) begin
                check_eq("rr_grant_timeout", 32'(gnt_o), 32'h1);
                break;
            end
            exp = exp_q.pop_front();
            own = int'(exp);
            check_eq("rr_order", 32'(gnt_o), 32'(4'b0001 << own));
            if (g > 0) check_eq("rr_gap", 32'(zeros), 32'd2);
            s_ack = 1'b1;
            settle();
            check_eq("rr_ack", 32'(m_ack_o), 32'(4'b0001 << own));
            step();
            s_ack = 1'b0;
            drop(own);
            step();
            request(own);
        end
        clear_inputs();
        step();
        step();
        step();

        // scenario: owner 2 read of BEEF
        reset_pulse();
        request(2);
        m_adr[32 +: 16] = 16'hA5A5;
        step();
        check_eq("rd_gnt2", 32'(gnt_o), 32'b0100);
        check_eq("rd_sadr", 32'(s_adr_o), 32'hA5A5);
        check_eq("rd_swe", 32'(s_we_o), 32'h0);
        s_dat = 16'hBEEF;
        s_ack = 1'b1;
        exp_q.push_back(32'hBEEF);
        settle();
        if (m_ack_o != 4'b0) begin
            exp = exp_q.pop_front();
            check_eq("rd_mdat", 32'(m_dat_o), exp);
        end
        check_eq("rd_ack", 32'(m_ack_o), 32'b0100);
        check_eq("rd_ack_others", 32'(m_ack_o & 4'b1011), 32'h0);
        s_ack = 1'b0;
        drop(2);
        step();
        step();

        // scenario: timeout abort (last owner 2, master 1 alone stalls)
        request(1);
        step();
        check_eq("to_gnt1", 32'(gnt_o), 32'b0010);
        stalled = 0;
        while (state_o == 2'd1 && stalled < 20) begin
            stalled++;
            check_eq("to_no_early_pulse", 32'(timeout_o), 32'h0);
            step();
        end
        check_eq("to_stall_cycles", 32'(stalled), 32'd5);
        check_eq("to_abort_state", 32'(state_o), 32'd2);
        exp_q.push_back(32'b0010);
        if (timeout_o) begin
            exp = exp_q.pop_front();
            check_eq("to_err", 32'(m_err_o), exp);
        end
        check_eq("to_pulse", 32'(timeout_o), 32'h1);
        check_eq("to_scyc", 32'(s_cyc_o), 32'h0);
        check_eq("to_sstb", 32'(s_stb_o), 32'h0);
        drop(1);
        step();
        check_eq("to_release", 32'(state_o), 32'd3);
        check_eq("to_pulse_one", 32'(timeout_o), 32'h0);
        check_eq("to_err_clear", 32'(m_err_o), 32'h0);
        step();
        check_eq("to_idle", 32'(state_o), 32'd0);

        // scenario: ack in the limit cycle beats the abort
        request(3);
        step();
        check_eq("race_gnt3", 32'(gnt_o), 32'b1000);
        for (int i = 0; i < 4; i++) step();
        s_ack = 1'b1;
        settle();
        check_eq("race_ack", 32'(m_ack_o), 32'b1000);
        step();
        s_ack = 1'b0;
        check_eq("race_still_busy", 32'(state_o), 32'd1);
        check_eq("race_no_pulse", 32'(timeout_o), 32'h0);
        for (int i = 0; i < 4; i++) step();
        check_eq("race_restart_busy", 32'(state_o), 32'd1);
        drop(3);
        step();
        step();

        // scenario: asynchronous reset mid-BUSY
        request(2);
        step();
        check_eq("ar_gnt2", 32'(gnt_o), 32'b0100);
        check_eq("ar_scyc_before", 32'(s_cyc_o), 32'h1);
        s_ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_scyc", 32'(s_cyc_o), 32'h0);
        check_eq("ar_gnt", 32'(gnt_o), 32'h0);
        check_eq("ar_ack", 32'(m_ack_o), 32'h0);
        check_eq("ar_state", 32'(state_o), 32'h0);
        s_ack = 1'b0;
        step();
        rst = 1'b0;
        m_cyc = 4'b0101;
        m_stb = 4'b0101;
        step();
        check_eq("ar_prio0", 32'(gnt_o), 32'b0001);
        clear_inputs();
        step();

        check_eq("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
